// File: rtl/adbg_tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adbg_tap_pkg
// Description : Shared TAP state encoding, default opcodes and the IR capture
//               pattern used by the JTAG TAP controller.
// Revision    : 1.0 - initial release
// ============================================================================
package adbg_tap_pkg;

  // The 16 states of the IEEE 1149.1 TAP controller.
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR        = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR        = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_state_e;

  // Default opcodes for a 4-bit instruction register.
  localparam logic [3:0] OPC_IDCODE = 4'h2;
  localparam logic [3:0] OPC_DEBUG  = 4'h8;
  localparam logic [3:0] OPC_BYPASS = 4'hF;

  // Two LSBs loaded into the IR shifter in CAPTURE_IR; upper bits are zero.
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage : adbg_tap_pkg
`default_nettype wire

// File: rtl/adbg_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : adbg_tap_fsm
// Description : IEEE 1149.1 TAP state machine driven by TMS, with Moore
//               decodes of the states the debug top cares about.
// Revision    : 1.0 - initial release
// ============================================================================
module adbg_tap_fsm
  import adbg_tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state,
  output tap_state_e state_next,
  output logic       test_logic_reset_o,
  output logic       run_test_idle_o,
  output logic       shift_dr_o,
  output logic       pause_dr_o,
  output logic       update_dr_o,
  output logic       capture_dr_o
);

  // State register; asynchronous reset acts as TRST.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) state <= TEST_LOGIC_RESET;
    else       state <= state_next;
  end

  // Next-state table and zero-latency strobe decode of the current state.
  always_comb begin
    state_next         = TEST_LOGIC_RESET;
    test_logic_reset_o = (state == TEST_LOGIC_RESET);
    run_test_idle_o    = (state == RUN_TEST_IDLE);
    shift_dr_o         = (state == SHIFT_DR);
    pause_dr_o         = (state == PAUSE_DR);
    update_dr_o        = (state == UPDATE_DR);
    capture_dr_o       = (state == CAPTURE_DR);
    case (state)
      TEST_LOGIC_RESET: state_next = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_next = tms_i ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms_i ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms_i ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms_i ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms_i ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms_i ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_next = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms_i ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms_i ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms_i ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms_i ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms_i ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

endmodule : adbg_tap_fsm
`default_nettype wire

// File: rtl/adbg_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adbg_tap_ctrl
// Description : JTAG TAP controller in front of the debug top. Holds the
//               instruction register, the IDCODE and BYPASS data registers
//               and the TDO multiplexer; DR strobes come from adbg_tap_fsm.
//               Build option ADBG_TAP_NEGEDGE_TDO_EN: when defined, TDO and
//               its enable are retimed to the falling edge of tck_i;
//               otherwise they are driven combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module adbg_tap_ctrl
  import adbg_tap_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_5DB3,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(OPC_IDCODE),
  parameter logic [IR_WIDTH-1:0] INSTR_DEBUG  = IR_WIDTH'(OPC_DEBUG),
  parameter logic [IR_WIDTH-1:0] INSTR_BYPASS = IR_WIDTH'(OPC_BYPASS)
) (
  input  logic tck_i,
  input  logic rst_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  input  logic debug_tdo_i,
  output logic test_logic_reset_o,
  output logic run_test_idle_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic debug_select_o
);

  tap_state_e          state;
  tap_state_e          state_next;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] instr_q;
  logic [31:0]         idcode_sr;
  logic                bypass_q;
  logic                is_idcode;
  logic                is_debug;
  logic                is_bypass;
  logic                tdo_next;
  logic                oe_next;

  adbg_tap_fsm u_fsm (
    .tck_i              (tck_i),
    .rst_i              (rst_i),
    .tms_i              (tms_i),
    .state              (state),
    .state_next         (state_next),
    .test_logic_reset_o (test_logic_reset_o),
    .run_test_idle_o    (run_test_idle_o),
    .shift_dr_o         (shift_dr_o),
    .pause_dr_o         (pause_dr_o),
    .update_dr_o        (update_dr_o),
    .capture_dr_o       (capture_dr_o)
  );

  // Any opcode that is neither IDCODE nor DEBUG selects the bypass bit.
  assign is_idcode      = (instr_q == INSTR_IDCODE);
  assign is_debug       = (instr_q == INSTR_DEBUG);
  assign is_bypass      = (instr_q == INSTR_BYPASS) | ~(is_idcode | is_debug);
  assign debug_select_o = is_debug;

  // IR shifter: capture the fixed pattern, then shift LSB first toward TDO.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      ir_shift <= '0;
    end else if (state == CAPTURE_IR) begin
      ir_shift <= {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE_LSBS};
    end else if (state == SHIFT_IR) begin
      ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]};
    end
  end

  // Active instruction. Keyed on the next state so the reset instruction is
  // already in place on the first cycle spent in TEST_LOGIC_RESET.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= INSTR_IDCODE;
    end else if (state_next == TEST_LOGIC_RESET) begin
      instr_q <= INSTR_IDCODE;
    end else if (state == UPDATE_IR) begin
      instr_q <= ir_shift;
    end
  end

  // IDCODE data register.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      idcode_sr <= '0;
    end else if (is_idcode && state == CAPTURE_DR) begin
      idcode_sr <= IDCODE_VALUE;
    end else if (is_idcode && state == SHIFT_DR) begin
      idcode_sr <= {tdi_i, idcode_sr[31:1]};
    end
  end

  // Single-bit BYPASS register: one tck of delay from TDI to TDO.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      bypass_q <= 1'b0;
    end else if (is_bypass && state == CAPTURE_DR) begin
      bypass_q <= 1'b0;
    end else if (is_bypass && state == SHIFT_DR) begin
      bypass_q <= tdi_i;
    end
  end

  // TDO source select; the output is only enabled while shifting.
  always_comb begin
    tdo_next = 1'b0;
    oe_next  = 1'b0;
    if (state == SHIFT_IR) begin
      tdo_next = ir_shift[0];
      oe_next  = 1'b1;
    end else if (state == SHIFT_DR) begin
      oe_next = 1'b1;
      if (is_idcode)     tdo_next = idcode_sr[0];
      else if (is_debug) tdo_next = debug_tdo_i;
      else               tdo_next = bypass_q;
    end
  end

`ifdef ADBG_TAP_NEGEDGE_TDO_EN
  // Launch TDO on the falling edge so the probe samples it on the next rise.
  always_ff @(negedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_o    <= tdo_next;
      tdo_oe_o <= oe_next;
    end
  end
`else
  assign tdo_o    = tdo_next;
  assign tdo_oe_o = oe_next;
`endif

endmodule : adbg_tap_ctrl
`default_nettype wire

// File: tb/tb_adbg_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adbg_tap_ctrl
// Description : Directed self-checking bench for adbg_tap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adbg_tap_ctrl;

  logic tck_i = 1'b0;
  logic rst_i;
  logic tms_i;
  logic tdi_i;
  logic debug_tdo_i;
  logic tdo_o;
  logic tdo_oe_o;
  logic test_logic_reset_o;
  logic run_test_idle_o;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic capture_dr_o;
  logic debug_select_o;

  int n_assert = 0;
  int n_fail   = 0;
  int n_shift  = 0;
  int n_cap    = 0;
  int n_upd    = 0;

  adbg_tap_ctrl dut (
    .tck_i              (tck_i),
    .rst_i              (rst_i),
    .tms_i              (tms_i),
    .tdi_i              (tdi_i),
    .tdo_o              (tdo_o),
    .tdo_oe_o           (tdo_oe_o),
    .debug_tdo_i        (debug_tdo_i),
    .test_logic_reset_o (test_logic_reset_o),
    .run_test_idle_o    (run_test_idle_o),
    .shift_dr_o         (shift_dr_o),
    .pause_dr_o         (pause_dr_o),
    .update_dr_o        (update_dr_o),
    .capture_dr_o       (capture_dr_o),
    .debug_select_o     (debug_select_o)
  );

  // 10 ns tck: rising edges at 5, 15, 25 ...
  always #5 tck_i = ~tck_i;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive TMS/TDI, take one rising edge, and tally the DR strobes seen after it.
  task automatic step(input logic tms, input logic tdi);
    tms_i = tms;
    tdi_i = tdi;
    @(posedge tck_i);
    #1;
    if (shift_dr_o)   n_shift++;
    if (capture_dr_o) n_cap++;
    if (update_dr_o)  n_upd++;
  endtask

  // Move past the falling edge, where TDO is valid in either TDO build.
  task automatic settle();
    @(negedge tck_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tlr"},     {31'd0, test_logic_reset_o}, 32'd1);
    check({pfx, "_rti"},     {31'd0, run_test_idle_o},    32'd0);
    check({pfx, "_shdr"},    {31'd0, shift_dr_o},         32'd0);
    check({pfx, "_padr"},    {31'd0, pause_dr_o},         32'd0);
    check({pfx, "_updr"},    {31'd0, update_dr_o},        32'd0);
    check({pfx, "_capdr"},   {31'd0, capture_dr_o},       32'd0);
    check({pfx, "_dbgsel"},  {31'd0, debug_select_o},     32'd0);
    check({pfx, "_tdo"},     {31'd0, tdo_o},              32'd0);
    check({pfx, "_tdo_oe"},  {31'd0, tdo_oe_o},           32'd0);
  endtask

  // From TLR/RTI: go to SHIFT_DR, shift 32 zeros, end in EXIT1_DR.
  task automatic read_idcode(output logic [31:0] val);
    logic oe_all;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    val    = '0;
    oe_all = 1'b1;
    for (int i = 0; i < 32; i++) begin
      settle();
      val[i] = tdo_o;
      oe_all = oe_all & tdo_oe_o;
      step(i == 31, 1'b0);
    end
    check("idcode_oe_during_shift", {31'd0, oe_all}, 32'd1);
    settle();
    check("idcode_oe_after_shift", {31'd0, tdo_oe_o}, 32'd0);
    check("idcode_tdo_after_shift", {31'd0, tdo_o}, 32'd0);
  endtask

  // From SELECT_DR: load an opcode through the IR, end in RUN_TEST_IDLE.
  task automatic load_ir(input logic [3:0] opc, output logic [3:0] captured);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    captured = '0;
    for (int i = 0; i < 4; i++) begin
      settle();
      captured[i] = tdo_o;
      step(i == 3, opc[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] idv;
    logic [3:0]  cap;
    logic [4:0]  byp;
    logic [3:0]  byp_in;
    logic        dbg_bit;

    rst_i       = 1'b1;
    tms_i       = 1'b1;
    tdi_i       = 1'b0;
    debug_tdo_i = 1'b0;
    #2;
    check_reset_outputs("reset");
    settle();
    rst_i = 1'b0;

    // IDCODE read straight out of reset.
    read_idcode(idv);
    check("idcode_value", idv, 32'h1000_5DB3);

    // Load DEBUG through the IR from EXIT1_DR.
    step(1'b1, 1'b0);
    check("update_dr_pulse", {31'd0, update_dr_o}, 32'd1);
    step(1'b1, 1'b0);
    load_ir(4'h8, cap);
    check("ir_capture_bits", {28'd0, cap}, 32'h1);
    check("debug_select_set", {31'd0, debug_select_o}, 32'd1);
    check("rti_after_update_ir", {31'd0, run_test_idle_o}, 32'd1);

    // DEBUG DR scan of 53 bits with a pause before update.
    n_shift = 0; n_cap = 0; n_upd = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 53; i++) begin
      dbg_bit     = logic'((i ^ (i >> 2)) & 1);
      debug_tdo_i = dbg_bit;
      settle();
      check("debug_tdo_track", {31'd0, tdo_o}, {31'd0, dbg_bit});
      step(i == 52, 1'b0);
    end
    debug_tdo_i = 1'b0;
    step(1'b0, 1'b0);
    check("pause_dr_strobe", {31'd0, pause_dr_o}, 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("debug_shift_count", n_shift, 32'd53);
    check("debug_capture_count", n_cap, 32'd1);
    check("debug_update_count", n_upd, 32'd1);

    // Undefined opcode 0x5 behaves as BYPASS.
    step(1'b1, 1'b0);
    load_ir(4'h5, cap);
    check("ir_capture_bits_2", {28'd0, cap}, 32'h1);
    check("debug_select_clear_undef", {31'd0, debug_select_o}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    byp_in = 4'b1101;
    byp    = '0;
    for (int i = 0; i < 5; i++) begin
      settle();
      byp[i] = tdo_o;
      step(i == 4, (i < 4) ? byp_in[i] : 1'b0);
    end
    check("bypass_delay", {27'd0, byp}, 32'b11010);

    // Reload DEBUG, enter SHIFT_DR, then five TMS=1 edges.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    load_ir(4'h8, cap);
    check("debug_select_again", {31'd0, debug_select_o}, 32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("in_shift_dr", {31'd0, shift_dr_o}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5_tlr", {31'd0, test_logic_reset_o}, 32'd1);
    check("tms5_debug_select", {31'd0, debug_select_o}, 32'd0);
    check("tms5_shift_dr", {31'd0, shift_dr_o}, 32'd0);

    // Asynchronous reset between edges in the middle of SHIFT_IR.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    settle();
    check("shift_ir_oe", {31'd0, tdo_oe_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("midreset");
    rst_i = 1'b0;
    read_idcode(idv);
    check("idcode_after_reset", idv, 32'h1000_5DB3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_adbg_tap_ctrl
`default_nettype wire
